stopwatch_core: RTL and testbench

- Timekeeping stage of the stopwatch. It sits directly upstream of the 4-digit display multiplexer.
- Takes debounced start/stop and clear button levels and runs a run/pause/idle state machine.
- Prescales the system clock to a 1 s tick and keeps an MM:SS BCD count.
- Drives four 7-segment patterns that feed the multiplexer's four digit inputs.

---
 rtl/stopwatch_pkg.sv | 53 +++++
 rtl/bcd_to_seg7.sv | 20 ++
 rtl/stopwatch_core.sv | 138 +++++++++++++
 tb/tb_stopwatch_core.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared types and constants for the stopwatch timekeeping stage.
//   sw_state_t     : run/pause/idle state encoding
//   SEG_LUT        : 7-segment patterns for digits 0-9 (bit0..bit6 = a..g, active-high)
//   SEG_BLANK      : pattern shown for a non-decimal BCD nibble
//   DIGIT_MAX_*    : last legal value of a tens / ones digit in an MM:SS count
//   COUNT_MAX      : 59:59 as packed BCD {min_t, min_o, sec_t, sec_o}
//   bcd_inc()      : MM:SS BCD increment with digit carries (59:59 rolls to 00:00)
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_t;

    localparam logic [6:0] SEG_LUT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    localparam logic [6:0]  SEG_BLANK      = 7'h00;
    localparam logic [3:0]  DIGIT_MAX_TENS = 4'd5;
    localparam logic [3:0]  DIGIT_MAX_ONES = 4'd9;
    localparam logic [15:0] COUNT_MAX      = 16'h5959;

    // Advance a packed MM:SS BCD value by one second, rippling carries upward.
    function automatic logic [15:0] bcd_inc(input logic [15:0] cur);
        logic [15:0] nxt_s;
        nxt_s = cur;
        if (cur[3:0] != DIGIT_MAX_ONES) begin
            nxt_s[3:0] = cur[3:0] + 4'd1;
        end else begin
            nxt_s[3:0] = 4'd0;
            if (cur[7:4] != DIGIT_MAX_TENS) begin
                nxt_s[7:4] = cur[7:4] + 4'd1;
            end else begin
                nxt_s[7:4] = 4'd0;
                if (cur[11:8] != DIGIT_MAX_ONES) begin
                    nxt_s[11:8] = cur[11:8] + 4'd1;
                end else begin
                    nxt_s[11:8] = 4'd0;
                    if (cur[15:12] != DIGIT_MAX_TENS) begin
                        nxt_s[15:12] = cur[15:12] + 4'd1;
                    end else begin
                        nxt_s[15:12] = 4'd0;
                    end
                end
            end
        end
        return nxt_s;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: one-digit BCD to 7-segment decoder.
//   bcd : 4-bit BCD digit
//   seg : segment pattern, bit0..bit6 = a..g, active-high; blank for values above 9
module bcd_to_seg7
    import stopwatch_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Table lookup, guarded so out-of-range nibbles never index past the table.
    always_comb begin
        if (bcd <= 4'd9) begin
            seg = SEG_LUT[bcd];
        end else begin
            seg = SEG_BLANK;
        end
    end

endmodule

// File: rtl/stopwatch_core.sv
// stopwatch_core: stopwatch timekeeping stage feeding the 4-digit display multiplexer.
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset (release is expected to be synchronous to clk)
//   start_stop : debounced level; rising edge toggles run/pause
//   clear      : debounced level; rising edge zeroes the count and returns to IDLE
//   seg0..seg3 : 7-segment patterns for sec ones, sec tens, min ones, min tens
//   bcd        : {min_t, min_o, sec_t, sec_o}
//   running    : high while in RUN
//   wrap       : one-cycle pulse on 59:59 -> 00:00 rollover
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000,
    parameter bit SATURATE = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_stop,
    input  logic        clear,
    output logic [6:0]  seg0,
    output logic [6:0]  seg1,
    output logic [6:0]  seg2,
    output logic [6:0]  seg3,
    output logic [15:0] bcd,
    output logic        running,
    output logic        wrap
);

    localparam int                 PRESC_W    = $clog2(TICK_DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [PRESC_W-1:0] PRESC_ZERO = {PRESC_W{1'b0}};
    localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);

    sw_state_t          state_r, state_s;
    logic [PRESC_W-1:0] presc_r, presc_s;
    logic [15:0]        count_r, count_s;
    logic               wrap_r, wrap_s;
    logic               running_r;
    logic               ss_hist_r, clr_hist_r;
    logic               ss_press_s, clr_press_s;
    logic               tick_s, at_max_s;

    // History flops reset high so a button held through reset is ignored until re-pressed.
    assign ss_press_s  = start_stop & ~ss_hist_r;
    assign clr_press_s = clear & ~clr_hist_r;
    assign tick_s      = (state_r == RUN) && (presc_r == PRESC_LAST);
    assign at_max_s    = (count_r == COUNT_MAX);

    // Next-state, prescaler and count update; clear overrides everything else.
    always_comb begin
        state_s = state_r;
        presc_s = presc_r;
        count_s = count_r;
        wrap_s  = 1'b0;
        if (clr_press_s) begin
            state_s = IDLE;
            presc_s = PRESC_ZERO;
            count_s = 16'h0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (ss_press_s) begin
                        state_s = RUN;
                        presc_s = PRESC_ZERO;
                    end else begin
                        state_s = IDLE;
                    end
                end
                RUN: begin
                    if (tick_s) begin
                        presc_s = PRESC_ZERO;
                        if (!at_max_s) begin
                            count_s = bcd_inc(count_r);
                        end else if (SATURATE) begin
                            count_s = COUNT_MAX;
                        end else begin
                            count_s = 16'h0000;
                            wrap_s  = 1'b1;
                        end
                    end else begin
                        presc_s = presc_r + PRESC_ONE;
                    end
                    // A press on a tick edge still lets the increment above land.
                    if (ss_press_s) begin
                        state_s = PAUSE;
                    end else if (tick_s && at_max_s && SATURATE) begin
                        state_s = PAUSE;
                    end else begin
                        state_s = RUN;
                    end
                end
                PAUSE: begin
                    if (ss_press_s) begin
                        state_s = RUN;
                    end else begin
                        state_s = PAUSE;
                    end
                end
                default: begin
                    state_s = IDLE;
                    presc_s = PRESC_ZERO;
                    count_s = 16'h0000;
                end
            endcase
        end
    end

    // State, counters, button history and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            presc_r    <= PRESC_ZERO;
            count_r    <= 16'h0000;
            wrap_r     <= 1'b0;
            running_r  <= 1'b0;
            ss_hist_r  <= 1'b1;
            clr_hist_r <= 1'b1;
        end else begin
            state_r    <= state_s;
            presc_r    <= presc_s;
            count_r    <= count_s;
            wrap_r     <= wrap_s;
            running_r  <= (state_s == RUN);
            ss_hist_r  <= start_stop;
            clr_hist_r <= clear;
        end
    end

    assign bcd     = count_r;
    assign running = running_r;
    assign wrap    = wrap_r;

    bcd_to_seg7 u_seg0 (.bcd(count_r[3:0]),   .seg(seg0));
    bcd_to_seg7 u_seg1 (.bcd(count_r[7:4]),   .seg(seg1));
    bcd_to_seg7 u_seg2 (.bcd(count_r[11:8]),  .seg(seg2));
    bcd_to_seg7 u_seg3 (.bcd(count_r[15:12]), .seg(seg3));

endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: drives a wrapping and a saturating stopwatch_core with the
// same buttons; a seconds-based reference model feeds a scoreboard every cycle,
// and a vector table plus hand sequences check hand-computed values.
module tb_stopwatch_core;

    localparam int TDIV = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_stop = 1'b0;
    logic clear = 1'b0;

    logic [6:0]  w_seg0, w_seg1, w_seg2, w_seg3;
    logic [15:0] w_bcd;
    logic        w_running, w_wrap;
    logic [6:0]  s_seg0, s_seg1, s_seg2, s_seg3;
    logic [15:0] s_bcd;
    logic        s_running, s_wrap;

    stopwatch_core #(.TICK_DIV(TDIV), .SATURATE(1'b0)) dut (
        .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear),
        .seg0(w_seg0), .seg1(w_seg1), .seg2(w_seg2), .seg3(w_seg3),
        .bcd(w_bcd), .running(w_running), .wrap(w_wrap)
    );

    stopwatch_core #(.TICK_DIV(TDIV), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear),
        .seg0(s_seg0), .seg1(s_seg1), .seg2(s_seg2), .seg3(s_seg3),
        .bcd(s_bcd), .running(s_running), .wrap(s_wrap)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] bcd;
        logic        run;
        logic        wrap;
        logic [6:0]  s3;
        logic [6:0]  s2;
        logic [6:0]  s1;
        logic [6:0]  s0;
    } obs_t;

    typedef struct {
        bit          ss;
        bit          clr;
        int          cycles;
        logic [15:0] bcd;
        bit          run;
        logic [15:0] bcd_sat;
        bit          run_sat;
    } vec_t;

    int tests_run = 0;
    int tests_failed = 0;

    obs_t sb0_q[$];
    obs_t sb1_q[$];
    obs_t rst_obs;

    // Reference model: total seconds 0..3599, prescale phase, state 0=idle 1=run 2=pause.
    int m_secs[2];
    int m_phase[2];
    int m_state[2];
    bit m_wrap[2];
    bit m_hss[2];
    bit m_hclr[2];

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic obs_t model_obs(input int k);
        obs_t o;
        int mm, sc;
        mm     = m_secs[k] / 60;
        sc     = m_secs[k] % 60;
        o.bcd  = {4'(mm / 10), 4'(mm % 10), 4'(sc / 10), 4'(sc % 10)};
        o.run  = (m_state[k] == 1);
        o.wrap = m_wrap[k];
        o.s0   = seg_of(sc % 10);
        o.s1   = seg_of(sc / 10);
        o.s2   = seg_of(mm % 10);
        o.s3   = seg_of(mm / 10);
        return o;
    endfunction

    function automatic obs_t dut_obs(input int k);
        obs_t o;
        if (k == 0) o = {w_bcd, w_running, w_wrap, w_seg3, w_seg2, w_seg1, w_seg0};
        else        o = {s_bcd, s_running, s_wrap, s_seg3, s_seg2, s_seg1, s_seg0};
        return o;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_secs[k] = 0; m_phase[k] = 0; m_state[k] = 0;
            m_wrap[k] = 1'b0; m_hss[k] = 1'b1; m_hclr[k] = 1'b1;
        end
    endtask

    task automatic model_step(input int k, input bit sat);
        bit ssp, clp;
        ssp = start_stop & ~m_hss[k];
        clp = clear & ~m_hclr[k];
        m_hss[k]  = start_stop;
        m_hclr[k] = clear;
        m_wrap[k] = 1'b0;
        if (clp) begin
            m_state[k] = 0; m_secs[k] = 0; m_phase[k] = 0;
        end else if (m_state[k] == 1) begin
            if (m_phase[k] == TDIV - 1) begin
                m_phase[k] = 0;
                if (m_secs[k] < 3599) m_secs[k] = m_secs[k] + 1;
                else if (sat) m_state[k] = 2;
                else begin m_secs[k] = 0; m_wrap[k] = 1'b1; end
            end else begin
                m_phase[k] = m_phase[k] + 1;
            end
            if (ssp) m_state[k] = 2;
        end else if (m_state[k] == 0) begin
            if (ssp) begin m_state[k] = 1; m_phase[k] = 0; end
        end else begin
            if (ssp) m_state[k] = 1;
        end
    endtask

    task automatic check_obs(input string name, input obs_t got, input obs_t exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s @%0t: got bcd=%h run=%b wrap=%b seg=%h/%h/%h/%h, expected bcd=%h run=%b wrap=%b seg=%h/%h/%h/%h",
                     name, $time, got.bcd, got.run, got.wrap, got.s3, got.s2, got.s1, got.s0,
                     exp.bcd, exp.run, exp.wrap, exp.s3, exp.s2, exp.s1, exp.s0);
        end
    endtask

    task automatic check_val(input string name, input int row, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s row %0d @%0t: got %h, expected %h", name, row, $time, got, exp);
        end
    endtask

    // One clock: model predicts, scoreboard holds the prediction until the DUT output is sampled.
    task automatic step();
        obs_t e0, e1;
        model_step(0, 1'b0);
        model_step(1, 1'b1);
        sb0_q.push_back(model_obs(0));
        sb1_q.push_back(model_obs(1));
        @(posedge clk);
        #1;
        e0 = sb0_q.pop_front();
        e1 = sb1_q.pop_front();
        check_obs("sb_wrap_dut", dut_obs(0), e0);
        check_obs("sb_sat_dut", dut_obs(1), e1);
    endtask

    vec_t vecs[20];

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 1,     16'h0000, 1'b1, 16'h0000, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 4,     16'h0001, 1'b1, 16'h0001, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 36,    16'h0010, 1'b1, 16'h0010, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 196,   16'h0059, 1'b1, 16'h0059, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 2,     16'h0059, 1'b1, 16'h0059, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 1,     16'h0059, 1'b0, 16'h0059, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 20,    16'h0059, 1'b0, 16'h0059, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1,     16'h0059, 1'b0, 16'h0059, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1,     16'h0059, 1'b1, 16'h0059, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 1,     16'h0100, 1'b1, 16'h0100, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 2,     16'h0100, 1'b1, 16'h0100, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 1,     16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1,     16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 1,     16'h0000, 1'b1, 16'h0000, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 3,     16'h0000, 1'b1, 16'h0000, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 1,     16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 1,     16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[17] = '{1'b1, 1'b0, 1,     16'h0000, 1'b1, 16'h0000, 1'b1};
        vecs[18] = '{1'b0, 1'b0, 14392, 16'h5958, 1'b1, 16'h5958, 1'b1};
        vecs[19] = '{1'b0, 1'b0, 4,     16'h5959, 1'b1, 16'h5959, 1'b1};

        rst_obs.bcd = 16'h0000; rst_obs.run = 1'b0; rst_obs.wrap = 1'b0;
        rst_obs.s0 = 7'h3F; rst_obs.s1 = 7'h3F; rst_obs.s2 = 7'h3F; rst_obs.s3 = 7'h3F;

        // Reset values, then buttons toggling while reset is held.
        #1;
        check_obs("reset_wrap_dut", dut_obs(0), rst_obs);
        check_obs("reset_sat_dut", dut_obs(1), rst_obs);
        for (int i = 0; i < 3; i++) begin
            start_stop = ~start_stop;
            clear      = (i == 1);
            @(posedge clk);
            #1;
            check_obs("reset_hold_wrap", dut_obs(0), rst_obs);
            check_obs("reset_hold_sat", dut_obs(1), rst_obs);
        end
        start_stop = 1'b0;
        clear      = 1'b0;
        rst        = 1'b0;
        model_reset();
        step();

        // Vector table: start, count, pause/resume, clear priority, preload to 59:59.
        for (int r = 0; r < 20; r++) begin
            start_stop = vecs[r].ss;
            clear      = vecs[r].clr;
            for (int c = 0; c < vecs[r].cycles; c++) step();
            check_val("tbl_bcd", r, {16'h0, w_bcd}, {16'h0, vecs[r].bcd});
            check_val("tbl_running", r, {31'h0, w_running}, {31'h0, vecs[r].run});
            check_val("tbl_bcd_sat", r, {16'h0, s_bcd}, {16'h0, vecs[r].bcd_sat});
            check_val("tbl_running_sat", r, {31'h0, s_running}, {31'h0, vecs[r].run_sat});
        end

        // Rollover: wrap pulses once on the wrapping DUT, the saturating DUT holds and pauses.
        start_stop = 1'b0;
        clear      = 1'b0;
        for (int c = 0; c < 3; c++) step();
        check_val("pre_wrap", 0, {31'h0, w_wrap}, 32'h0);
        step();
        check_val("wrap_pulse", 0, {31'h0, w_wrap}, 32'h1);
        check_val("wrap_bcd", 0, {16'h0, w_bcd}, 32'h0000);
        check_val("wrap_running", 0, {31'h0, w_running}, 32'h1);
        check_val("sat_bcd", 0, {16'h0, s_bcd}, 32'h5959);
        check_val("sat_running", 0, {31'h0, s_running}, 32'h0);
        check_val("sat_wrap", 0, {31'h0, s_wrap}, 32'h0);
        step();
        check_val("wrap_one_cycle", 0, {31'h0, w_wrap}, 32'h0);
        check_val("sat_hold", 0, {16'h0, s_bcd}, 32'h5959);

        // start_stop held across reset release must not start the count.
        start_stop = 1'b1;
        rst        = 1'b1;
        #1;
        check_obs("reset_async_wrap", dut_obs(0), rst_obs);
        check_obs("reset_async_sat", dut_obs(1), rst_obs);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 3; c++) step();
        check_val("held_no_run", 0, {31'h0, w_running}, 32'h0);
        start_stop = 1'b0;
        step();
        start_stop = 1'b1;
        step();
        check_val("repress_run", 0, {31'h0, w_running}, 32'h1);

        // Count to 12:34, then reset asynchronously between clock edges.
        start_stop = 1'b0;
        for (int c = 0; c < 754 * TDIV; c++) step();
        check_val("count_1234", 0, {16'h0, w_bcd}, 32'h1234);
        check_val("count_1234_sat", 0, {16'h0, s_bcd}, 32'h1234);
        rst = 1'b1;
        #1;
        check_obs("reset_mid_wrap", dut_obs(0), rst_obs);
        check_obs("reset_mid_sat", dut_obs(1), rst_obs);
        @(posedge clk);
        #1;
        check_obs("reset_mid_hold", dut_obs(0), rst_obs);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
